// File: rtl/router_arbiter_rr_if.sv
// router_arbiter_rr_if: request inputs and cfg/ack outputs of the 3x3 router arbiter
interface router_arbiter_rr_if;
  logic [2:0] pe_request_bundle;
  logic [2:0] north_request_bundle;
  logic [2:0] east_request_bundle;
  logic [2:0] west_cfg_bundle;
  logic [2:0] south_cfg_bundle;
  logic [1:0] pe_cfg_bundle;
  logic       east_ack;
  logic       north_ack;
  logic       r2pe_ack;
  logic       pe_route_err;
  modport master (
    output pe_request_bundle, north_request_bundle, east_request_bundle,
    input  west_cfg_bundle, south_cfg_bundle, pe_cfg_bundle,
    input  east_ack, north_ack, r2pe_ack, pe_route_err
  );
  modport slave (
    input  pe_request_bundle, north_request_bundle, east_request_bundle,
    output west_cfg_bundle, south_cfg_bundle, pe_cfg_bundle,
    output east_ack, north_ack, r2pe_ack, pe_route_err
  );
endinterface

// File: rtl/router_arbiter_rr.sv
// router_arbiter_rr: per-output packet arbiter (west/south/pe) for east/north/pe inputs
module router_arbiter_rr #(
  parameter int PACKET_FLITS = 4,
  parameter int RR_MODE = 1
) (
  input logic clk,
  input logic reset,
  router_arbiter_rr_if.slave bus
);
  localparam int CW = $clog2(PACKET_FLITS + 1);
  localparam logic [CW-1:0] LAST = CW'(PACKET_FLITS - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        st   [3];
  logic [CW-1:0] cnt  [3];
  logic [1:0]    ptr  [3];
  logic [1:0]    own  [3];
  logic [1:0]    win  [3];
  logic [2:0]    cfg  [3];
  logic [2:0]    req  [3];
  logic [2:0]    cand [3];
  logic [2:0]    lock, ack_n, ack_q, elig, grant;
  logic          err_q;
  // inputs and outputs are indexed 0=east/west, 1=north/south, 2=pe
  function automatic logic [1:0] dst(input logic [2:0] r);
    return r[2:1] == 2'b11 ? 2'd2 : {1'b0, r[2]};
  endfunction
  function automatic logic [1:0] pick(input logic [2:0] c, input logic [1:0] p);
    logic [1:0] idx;
    pick = 2'd3;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(p) + k) % 3);
      if (c[idx]) pick = idx;
    end
  endfunction
  function automatic logic [2:0] enc(input int o, input logic [1:0] w);
    return o == 2 ? {1'b0, w == 2'd0, 1'b1} : w == 2'd0 ? 3'b111 : w == 2'd1 ? 3'b101 : 3'b001;
  endfunction
  assign req[0] = bus.east_request_bundle;
  assign req[1] = bus.north_request_bundle;
  assign req[2] = bus.pe_request_bundle;
  assign bus.west_cfg_bundle  = cfg[0];
  assign bus.south_cfg_bundle = cfg[1];
  assign bus.pe_cfg_bundle    = cfg[2][1:0];
  assign bus.east_ack     = ack_q[0];
  assign bus.north_ack    = ack_q[1];
  assign bus.r2pe_ack     = ack_q[2];
  assign bus.pe_route_err = err_q;
  // an input stays locked while its owner is mid-packet; at the last flit it may compete again
  always_comb begin
    lock = '0;
    elig = '0;
    grant = '0;
    ack_n = '0;
    for (int o = 0; o < 3; o++) begin
      cand[o] = '0;
      win[o] = 2'd3;
    end
    for (int i = 0; i < 3; i++)
      for (int o = 0; o < 3; o++)
        if (st[o] == BUSY && cnt[o] != LAST && own[o] == 2'(i)) lock[i] = 1'b1;
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 3; i++)
        cand[o][i] = req[i][0] && dst(req[i]) == 2'(o) && !lock[i] && !(i == 2 && req[i][2:1] == 2'b11);
      elig[o] = st[o] == IDLE || cnt[o] == LAST;
      win[o] = pick(cand[o], RR_MODE != 0 ? ptr[o] : 2'd0);
      grant[o] = elig[o] && win[o] != 2'd3;
      for (int i = 0; i < 3; i++)
        if (grant[o] && win[o] == 2'(i)) ack_n[i] = 1'b1;
    end
  end
  // per-output IDLE/BUSY FSM with flit counter, pointer and registered cfg/ack/err outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < 3; o++) begin
        st[o] <= IDLE;
        cnt[o] <= '0;
        ptr[o] <= 2'd0;
        own[o] <= 2'd0;
        cfg[o] <= 3'b000;
      end
      ack_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (grant[o]) begin
          st[o] <= BUSY;
          cnt[o] <= '0;
          own[o] <= win[o];
          cfg[o] <= enc(o, win[o]);
          if (RR_MODE != 0) ptr[o] <= win[o] == 2'd2 ? 2'd0 : win[o] + 2'd1;
        end else if (st[o] == BUSY) begin
          if (cnt[o] == LAST) begin
            st[o] <= IDLE;
            cfg[o] <= 3'b000;
          end else begin
            cnt[o] <= cnt[o] + CW'(1);
          end
        end
      end
      ack_q <= ack_n;
      err_q <= req[2] == 3'b111;
    end
  end
endmodule

// File: doc/router_arbiter_rr.md
ROUTER_ARBITER_RR -- requirements
Module: router_arbiter_rr

Interface
REQ-001 Parameter PACKET_FLITS, default 4, meaning flits per packet; the block SHALL hold a granted output for this many cycles (legal range 1..255).
REQ-002 Parameter RR_MODE, default 1, meaning 1 = round-robin per output, 0 = fixed priority east > north > pe.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pe_request_bundle, north_request_bundle, east_request_bundle  input  3 each  {hit_x, hit_y, request}.
REQ-006 west_cfg_bundle, south_cfg_bundle  output  3 each  {mux_ctrl[1:0], toggle}: EAST=111, NORTH=101, PE=001, NULL=000.
REQ-007 pe_cfg_bundle  output  2  ejection mux: east=11, north=01, NULL=00.
REQ-008 east_ack, north_ack, r2pe_ack  output  1 each  one-cycle pulse marking acceptance of that input's packet.
REQ-009 pe_route_err  output  1  registered flag: a PE request with hit_x=1, hit_y=1 was present in the previous cycle.

Function
REQ-010 Destination decode: {hit_x,hit_y} = 00 or 01 -> west; 10 -> south; 11 -> pe ejection (east/north only).
REQ-011 A PE request with {hit_x,hit_y}=11 SHALL never be granted or acked; pe_route_err SHALL be 1 in the cycle after each cycle it is present.
REQ-012 Each of the three outputs (west, south, pe) SHALL have its own FSM: IDLE, BUSY; plus a flit counter of clog2(PACKET_FLITS+1) bits and a 3-entry priority pointer.
REQ-013 An output is eligible to arbitrate in a cycle when it is IDLE, or BUSY with counter == PACKET_FLITS-1 (last flit).
REQ-014 Candidates for an output are inputs with request=1, decoded destination equal to that output, and not currently locked.
REQ-015 An eligible output with >=1 candidate SHALL grant exactly one, chosen by RR_MODE: 0 -> east > north > pe; 1 -> first candidate at or after the pointer, in cyclic order east, north, pe.
REQ-016 After a grant with RR_MODE=1, the pointer SHALL move to the input after the winner; without a grant, or with RR_MODE=0, it SHALL hold.
REQ-017 Latency: with request sampled at edge t, the cfg value and the ack pulse SHALL both be visible in the cycle after edge t (registered, one cycle).
REQ-018 Upon grant, the output SHALL enter BUSY with counter=0, hold its cfg value for PACKET_FLITS cycles, and increment the counter each cycle.
REQ-019 Last flit with no new grant: the output SHALL return to IDLE and drive NULL in the following cycle.
REQ-020 Last flit with a new grant: the output SHALL switch cfg directly to the new winner with no NULL bubble.
REQ-021 The granted input SHALL be locked (masked from arbitration) from the grant edge through its last flit.
REQ-022 If a locked input's request is still asserted after release, the block SHALL treat it as a new packet.
REQ-023 Inputs SHALL hold request until their ack; a request withdrawn before ack SHALL be dropped without side effects.
REQ-024 Different outputs SHALL arbitrate independently in the same cycle; each input has a single destination, so all three acks may pulse together.
REQ-025 Acks SHALL be one cycle wide per grant, never level.
REQ-026 PACKET_FLITS=1: every cycle is a last flit; back-to-back grants to the same output SHALL be possible every cycle.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL: set all cfg outputs to NULL; clear all acks and pe_route_err; set all FSMs to IDLE and counters to 0; clear all locks; point all pointers to east.
REQ-028 Reset asserted mid-packet SHALL abort the packet; the first grant is possible at the first edge with reset=0.

Verification (PACKET_FLITS=4 unless stated)
REQ-029 East req hit=00 alone -> next cycle west_cfg_bundle=111, east_ack=1 for 1 cycle; 111 held 4 cycles; then 000.
REQ-030 RR_MODE=1, east and north both hit=10, held continuously -> south grants east(4 cycles), north(4 cycles), east... with no NULL cycles between; acks alternate.
REQ-031 RR_MODE=0, same stimulus -> east regranted every 4 cycles; north_ack never asserts.
REQ-032 East hit=00, north hit=11, pe hit=10 in the same cycle -> next cycle west=111, pe_cfg=01, south=001; all three acks=1.
REQ-033 PE hit=11 for 3 cycles -> pe_route_err=1 for 3 cycles, lagging by 1; r2pe_ack stays 0; all cfg outputs stay NULL.
REQ-034 Reset pulse at flit 2 of a west packet -> next cycle all outputs NULL; after release, a still-pending east request is regranted 1 cycle later.
